// File: rtl/upct_plru.sv
// Upper-PC table: indexed fetch read plus CAM-or-allocate update, with tree-PLRU
// replacement, invalid-first allocation, flush and write-to-read bypass.
module upct_plru #(
    parameter int unsigned UPCT_ENTRIES     = 8,
    parameter int unsigned LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
    parameter int unsigned UPPER_PC_WIDTH   = 21
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        read_valid_in,
    input  logic [LOG_UPCT_ENTRIES-1:0] read_index_in,
    output logic [UPPER_PC_WIDTH-1:0]   read_upper_PC_out,
    input  logic                        update0_valid_in,
    input  logic [UPPER_PC_WIDTH-1:0]   update0_upper_PC_in,
    output logic                        update1_valid_out,
    output logic [LOG_UPCT_ENTRIES-1:0] update1_upct_index_out,
    input  logic                        flush_in
);

    localparam int unsigned N     = UPCT_ENTRIES;
    localparam int unsigned LOG   = LOG_UPCT_ENTRIES;
    localparam int unsigned UPW   = UPPER_PC_WIDTH;
    localparam int unsigned NODES = UPCT_ENTRIES - 1;

    // Heap-ordered tree: node n (root = 1) lives at bit n-1, children are 2n and 2n+1.
    function automatic logic [LOG-1:0] plru_victim(input logic [NODES-1:0] t);
        int unsigned node;
        node = 1;
        for (int unsigned l = 0; l < LOG; l++) begin
            node = 2 * node + 32'(t[node-1]);
        end
        return LOG'(node - N);
    endfunction

    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t,
                                                    input logic [LOG-1:0]   idx);
        int unsigned node;
        logic        b;
        node = 1;
        for (int unsigned l = 0; l < LOG; l++) begin
            b         = idx[LOG-1-l];
            t[node-1] = ~b;
            node      = 2 * node + 32'(b);
        end
        return t;
    endfunction

    logic [N-1:0]     valid_q, valid_d;
    logic [UPW-1:0]   upc_q [N];
    logic [UPW-1:0]   upc_d [N];
    logic [NODES-1:0] plru_q, plru_d;
    logic [UPW-1:0]   rd_data_q, rd_data_d;
    logic             upd_valid_q, upd_valid_d;
    logic [LOG-1:0]   upd_idx_q, upd_idx_d;

    logic [N-1:0]     valid_base;
    logic [NODES-1:0] plru_base;
    logic             hit, free_found;
    logic [LOG-1:0]   hit_idx, free_idx, upd_idx;

    // Flush is folded in first, so the CAM, allocation and touches all see the cleared table.
    always_comb begin
        valid_base = flush_in ? '0 : valid_q;
        plru_base  = flush_in ? '0 : plru_q;
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (valid_base[i] && (upc_q[i] == update0_upper_PC_in)) begin
                hit     = 1'b1;
                hit_idx = LOG'(i);
            end
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!valid_base[i]) begin
                free_found = 1'b1;
                free_idx   = LOG'(i);
            end
        end
        upd_idx = hit ? hit_idx : (free_found ? free_idx : plru_victim(plru_base));
    end

    always_comb begin
        valid_d     = valid_base;
        upc_d       = upc_q;
        plru_d      = plru_base;
        rd_data_d   = rd_data_q;
        upd_valid_d = update0_valid_in;
        upd_idx_d   = upd_idx_q;
        if (update0_valid_in) begin
            upd_idx_d = upd_idx;
            if (!hit) begin
                upc_d[upd_idx]   = update0_upper_PC_in;
                valid_d[upd_idx] = 1'b1;
            end
        end
        // Reading the post-write array gives the same-cycle bypass.
        if (read_valid_in) begin
            rd_data_d = upc_d[read_index_in];
            plru_d    = plru_touch(plru_d, read_index_in);
        end
        if (update0_valid_in) begin
            plru_d = plru_touch(plru_d, upd_idx);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q     <= '0;
            plru_q      <= '0;
            rd_data_q   <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            for (int i = 0; i < int'(N); i++) begin
                upc_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            plru_q      <= plru_d;
            rd_data_q   <= rd_data_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            for (int i = 0; i < int'(N); i++) begin
                upc_q[i] <= upc_d[i];
            end
        end
    end

    assign read_upper_PC_out      = rd_data_q;
    assign update1_valid_out      = upd_valid_q;
    assign update1_upct_index_out = upd_idx_q;

endmodule
